// File: rtl/counter_10_pkg.sv
// Shared constants for the modulo-N counter: default count length and output width.
package counter_10_pkg;

  localparam int DEFAULT_MODULUS = 10;
  localparam int DEFAULT_WIDTH   = 4;

endpackage : counter_10_pkg

// File: rtl/counter_10.sv
// Enabled modulo-MODULUS up-counter with asynchronous active-high reset.
// The output is taken straight from the count register.
module counter_10
  import counter_10_pkg::*;
#(
  parameter int MODULUS = DEFAULT_MODULUS,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] LAST_VALUE = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  generate
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
      $error("counter_10: MODULUS %0d outside legal range 2..2**WIDTH", MODULUS);
    end
  endgenerate

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  // Values at or beyond the last legal count (including unreachable illegal ones) wrap to 0.
  always_comb begin
    out_d = out_q;
    if (enable) begin
      if (out_q >= LAST_VALUE) begin
        out_d = '0;
      end else begin
        out_d = out_q + ONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : counter_10

// File: tb/tb_counter_10.sv
// Self-checking bench for counter_10: directed timeline, vector table,
// mid-count async reset, and randomized run against a modulo-arithmetic model.
module tb_counter_10;

  localparam int MODULUS = 10;
  localparam int WIDTH   = 4;

  logic             clock;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] out;

  int tests_run;
  int tests_failed;
  int model_count;

  typedef struct {
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] expected;
    string            name;
  } vec_t;

  vec_t vecs[14];

  counter_10 #(
    .MODULUS(MODULUS),
    .WIDTH  (WIDTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .out   (out)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] expected);
    tests_run++;
    if (out !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: out=%0d expected=%0d at t=%0t", name, out, expected, $time);
    end
  endtask

  // Inputs change on the falling edge; the result is sampled just after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic en);
    @(negedge clock);
    reset  = rst;
    enable = en;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    enable       = 1'b0;

    vecs[0]  = '{1'b0, 1'b1, 4'd7, "count_7"};
    vecs[1]  = '{1'b0, 1'b1, 4'd8, "count_8"};
    vecs[2]  = '{1'b0, 1'b1, 4'd9, "count_9"};
    vecs[3]  = '{1'b0, 1'b1, 4'd0, "wrap_to_0"};
    vecs[4]  = '{1'b0, 1'b1, 4'd1, "after_wrap_1"};
    vecs[5]  = '{1'b0, 1'b0, 4'd1, "hold_1"};
    vecs[6]  = '{1'b0, 1'b1, 4'd2, "resume_2"};
    vecs[7]  = '{1'b1, 1'b1, 4'd0, "reset_over_enable"};
    vecs[8]  = '{1'b1, 1'b1, 4'd0, "reset_held"};
    vecs[9]  = '{1'b0, 1'b0, 4'd0, "released_idle"};
    vecs[10] = '{1'b0, 1'b1, 4'd1, "first_after_reset"};
    vecs[11] = '{1'b0, 1'b1, 4'd2, "count_2"};
    vecs[12] = '{1'b0, 1'b0, 4'd2, "pause_2"};
    vecs[13] = '{1'b0, 1'b1, 4'd3, "count_3"};

    // Reset window 5..15 with no clock edge yet seen: clear must be immediate.
    #5;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_t6", 4'd0);
    #9;
    reset = 1'b0;
    #6;
    checkOutput("idle_t21", 4'd0);
    #4;
    checkOutput("idle_t25", 4'd0);
    enable = 1'b1;

    for (int k = 1; k <= 16; k++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("run_edge_%0d", k), WIDTH'(k % MODULUS));
    end

    @(negedge clock);
    enable = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("hold_t191", 4'd6);
    @(posedge clock);
    #1;
    checkOutput("hold_t201", 4'd6);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en);
      checkOutput(vecs[i].name, vecs[i].expected);
    end

    // Bring count from 3 to 7, then pulse reset between edges.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("reach_7", 4'd7);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("midcount_reset_immediate", 4'd0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midcount_reset_before_edge", 4'd0);
    @(posedge clock);
    #1;
    checkOutput("restart_from_0", 4'd1);

    model_count = 1;
    for (int i = 0; i < 300; i++) begin
      logic rnd_rst;
      logic rnd_en;
      rnd_rst = ($urandom_range(0, 19) == 0);
      rnd_en  = $urandom_range(0, 1) == 1;
      applyStimulus(rnd_rst, rnd_en);
      if (rnd_rst) model_count = 0;
      else if (rnd_en) model_count = (model_count + 1) % MODULUS;
      checkOutput($sformatf("random_%0d", i), WIDTH'(model_count));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_counter_10
